// File: rtl/buscador_minimo.sv
`default_nettype none
// ============================================================================
// Module      : buscador_minimo
// Description : Frame minimum finder. After a one-cycle start request, it
//               accepts up to 16 unsigned 2-bit samples (qualified by
//               in_valid), tracks the smallest value and the position where
//               it first appeared, and publishes the result with a one-cycle
//               done pulse. A frame ends on in_last or when the 16th sample
//               is accepted without in_last (overflow).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1  system clock, rising-edge active
//   rst        in   1  synchronous active-high reset
//   start      in   1  begin a new frame (honoured only when idle)
//   in_valid   in   1  in_data / in_last valid this cycle
//   in_data    in   2  unsigned sample
//   in_last    in   1  final sample of the frame
//   busy       out  1  high while a frame is being captured
//   done       out  1  one-cycle pulse, result outputs are fresh
//   min_val    out  2  smallest sample of the last completed frame
//   min_idx    out  4  zero-based position of that sample
//   n_samples  out  5  samples accepted in the last completed frame (1..16)
//   overflow   out  1  last frame was cut at 16 samples without in_last
// ============================================================================
module buscador_minimo (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    input  logic [1:0] in_data,
    input  logic       in_last,
    output logic       busy,
    output logic       done,
    output logic [1:0] min_val,
    output logic [3:0] min_idx,
    output logic [4:0] n_samples,
    output logic       overflow
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Sample count at which the next accepted sample is the 16th one.
    localparam logic [4:0] c_LAST_SLOT = 5'd15;

    state_t     r_state;
    logic [4:0] r_cnt;        // samples accepted so far in this frame
    logic [1:0] r_run_min;    // running minimum
    logic [3:0] r_run_idx;    // position of the running minimum
    logic       r_busy;
    logic       r_done;
    logic [1:0] r_min_val;
    logic [3:0] r_min_idx;
    logic [4:0] r_n_samples;
    logic       r_overflow;

    // ------------------------------------------------------------------
    // Candidate update for the sample presented this cycle. The first
    // sample loads unconditionally; later ones only win on strictly-less,
    // so ties keep the earliest index.
    // ------------------------------------------------------------------
    logic       w_first;
    logic       w_take;
    logic [1:0] w_new_min;
    logic [3:0] w_new_idx;
    logic [4:0] w_new_cnt;
    logic       w_final;

    always_comb begin
        w_first   = (r_cnt == 5'd0);
        w_take    = w_first || (in_data < r_run_min);
        w_new_min = w_take ? in_data : r_run_min;
        w_new_idx = w_take ? r_cnt[3:0] : r_run_idx;
        w_new_cnt = r_cnt + 5'd1;
        // Frame closes either on an explicit last marker or when the
        // sample fills the final slot.
        w_final   = in_last || (r_cnt == c_LAST_SLOT);
    end

    // ------------------------------------------------------------------
    // Control FSM with registered outputs. Reset wins over every other
    // input and discards any partial frame.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cnt       <= 5'd0;
            r_run_min   <= 2'd0;
            r_run_idx   <= 4'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_min_val   <= 2'd0;
            r_min_idx   <= 4'd0;
            r_n_samples <= 5'd0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    // A sample coinciding with start is deliberately not
                    // accepted; capture begins on the following cycle.
                    if (start) begin
                        r_state   <= CAPTURE;
                        r_busy    <= 1'b1;
                        r_cnt     <= 5'd0;
                        r_run_min <= 2'd0;
                        r_run_idx <= 4'd0;
                    end
                end

                CAPTURE: begin
                    if (in_valid) begin
                        r_cnt     <= w_new_cnt;
                        r_run_min <= w_new_min;
                        r_run_idx <= w_new_idx;
                        if (w_final) begin
                            r_state     <= DONE;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_min_val   <= w_new_min;
                            r_min_idx   <= w_new_idx;
                            r_n_samples <= w_new_cnt;
                            r_overflow  <= ~in_last;
                        end
                    end
                end

                DONE: begin
                    // Single-cycle state; anything presented here is dropped.
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end

                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign min_val   = r_min_val;
    assign min_idx   = r_min_idx;
    assign n_samples = r_n_samples;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_buscador_minimo.sv
`default_nettype none
// ============================================================================
// Module      : tb_buscador_minimo
// Description : Directed self-checking bench for buscador_minimo. Inputs are
//               driven 1 time unit after each rising edge and outputs are
//               sampled at the same point, so every check sees the state
//               produced by the preceding edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_buscador_minimo;

    logic       clk;
    logic       rst;
    logic       start;
    logic       in_valid;
    logic [1:0] in_data;
    logic       in_last;
    logic       busy;
    logic       done;
    logic [1:0] min_val;
    logic [3:0] min_idx;
    logic [4:0] n_samples;
    logic       overflow;

    int total;
    int bad;

    buscador_minimo dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .busy      (busy),
        .done      (done),
        .min_val   (min_val),
        .min_idx   (min_idx),
        .n_samples (n_samples),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one valid sample for exactly one cycle.
    task automatic send(input logic [1:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_data  = 2'd0;
        in_last  = 1'b0;
    endtask

    task automatic begin_frame;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic chk_result(input string tag, input logic [1:0] mv, input logic [3:0] mi,
                              input logic [4:0] ns, input logic ov);
        chk({tag, "_done"},  {31'd0, done},      32'd1);
        chk({tag, "_busy"},  {31'd0, busy},      32'd0);
        chk({tag, "_min"},   {30'd0, min_val},   {30'd0, mv});
        chk({tag, "_idx"},   {28'd0, min_idx},   {28'd0, mi});
        chk({tag, "_n"},     {27'd0, n_samples}, {27'd0, ns});
        chk({tag, "_ovf"},   {31'd0, overflow},  {31'd0, ov});
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 2'd0;
        in_last  = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_busy", {31'd0, busy},      32'd0);
        chk("rst_done", {31'd0, done},      32'd0);
        chk("rst_min",  {30'd0, min_val},   32'd0);
        chk("rst_idx",  {28'd0, min_idx},   32'd0);
        chk("rst_n",    {27'd0, n_samples}, 32'd0);
        chk("rst_ovf",  {31'd0, overflow},  32'd0);

        // Frame A: 3,2,1,2(last) -> min 1 @2, n 4
        begin_frame();
        chk("a_busy", {31'd0, busy}, 32'd1);
        send(2'd3, 1'b0);
        send(2'd2, 1'b0);
        send(2'd1, 1'b0);
        chk("a_nodone", {31'd0, done}, 32'd0);
        send(2'd2, 1'b1);
        chk_result("a", 2'd1, 4'd2, 5'd4, 1'b0);
        tick();
        chk("a_pulse", {31'd0, done}, 32'd0);
        chk("a_hold",  {30'd0, min_val}, 32'd1);

        // Frame B: 2,0,3,0(last) with idle gaps -> min 0 @1 (earliest tie)
        begin_frame();
        send(2'd2, 1'b0);
        tick();
        send(2'd0, 1'b0);
        tick();
        tick();
        send(2'd3, 1'b0);
        send(2'd0, 1'b1);
        chk_result("b", 2'd0, 4'd1, 5'd4, 1'b0);

        // Frame C: 16 x 3 without last -> overflow; 17th sample ignored
        tick();
        begin_frame();
        for (int i = 0; i < 15; i++) send(2'd3, 1'b0);
        chk("c_busy15", {31'd0, busy}, 32'd1);
        chk("c_nodone", {31'd0, done}, 32'd0);
        send(2'd3, 1'b0);
        chk_result("c", 2'd3, 4'd0, 5'd16, 1'b1);
        send(2'd0, 1'b0);
        chk("c_idle_busy", {31'd0, busy},      32'd0);
        chk("c_idle_done", {31'd0, done},      32'd0);
        chk("c_hold_min",  {30'd0, min_val},   32'd3);
        chk("c_hold_n",    {27'd0, n_samples}, 32'd16);
        tick();
        chk("c_still_idle", {31'd0, busy}, 32'd0);

        // Frame D: single sample 2(last)
        begin_frame();
        send(2'd2, 1'b1);
        chk_result("d", 2'd2, 4'd0, 5'd1, 1'b0);
        tick();

        // Frame E: 16th sample carries last -> normal end; start mid-frame ignored
        begin_frame();
        for (int i = 0; i < 15; i++) begin
            if (i == 4) start = 1'b1;
            send(2'd2, 1'b0);
            start = 1'b0;
        end
        send(2'd1, 1'b1);
        chk_result("e", 2'd1, 4'd15, 5'd16, 1'b0);
        tick();

        // Frame F: reset mid-frame discards partial result
        begin_frame();
        send(2'd1, 1'b0);
        send(2'd0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("f_busy", {31'd0, busy},      32'd0);
        chk("f_done", {31'd0, done},      32'd0);
        chk("f_min",  {30'd0, min_val},   32'd0);
        chk("f_idx",  {28'd0, min_idx},   32'd0);
        chk("f_n",    {27'd0, n_samples}, 32'd0);
        chk("f_ovf",  {31'd0, overflow},  32'd0);
        send(2'd0, 1'b1);
        chk("f_nodone", {31'd0, done}, 32'd0);
        begin_frame();
        send(2'd3, 1'b1);
        chk_result("f2", 2'd3, 4'd0, 5'd1, 1'b0);
        tick();

        // Reset wins over a simultaneous start
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        chk("g_rst_prio", {31'd0, busy}, 32'd0);

        // Frame H: sample coinciding with start is not accepted
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 2'd0;
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        chk("h_busy", {31'd0, busy}, 32'd1);
        send(2'd2, 1'b0);
        send(2'd3, 1'b1);
        chk_result("h", 2'd2, 4'd0, 5'd2, 1'b0);
        tick();
        chk("h_pulse", {31'd0, done}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
